sysid_checker: RTL and testbench

Sequencer that owns the read port of the system-ID slave. On a `start` pulse it reads the ID word (address 0) and the timestamp word (address 1) with a configurable read latency, and compares both against expected values. On mismatch it retries up to a bound, then latches pass/fail status. It sits between the boot/control logic and the sysid slave, so software and hardware gate on a verified build identity.

---
 rtl/sysid_checker.sv | 136 +++++++++++++
 tb/tb_sysid_checker.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - system-ID read sequencer with bounded-retry ID/timestamp verification
// Define SYSID_CHECK_TIMESTAMP_EN to also read and check the timestamp word at address 1.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1390424643,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sys_address,
    output logic        sys_read,
    input  logic [31:0] sys_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [2:0]  retry_count
);

`ifdef SYSID_CHECK_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    localparam logic [2:0] LAT_LAST  = 3'(READ_LATENCY);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_CHECK,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [2:0] r_lat;

    logic w_lat_hit;
    logic w_id_match;
    logic w_ts_match;

    assign w_lat_hit  = (r_lat == LAT_LAST);
    assign w_id_match = (id_value == EXPECTED_ID);
    // Without the timestamp read the timestamp verdict is a constant pass.
    assign w_ts_match = TS_EN ? (ts_value == EXPECTED_TIMESTAMP) : 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lat       <= 3'd0;
            sys_address <= 1'b0;
            sys_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            retry_count <= 3'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RD_ID;
                        r_lat       <= 3'd0;
                        busy        <= 1'b1;
                        sys_read    <= 1'b1;
                        sys_address <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        retry_count <= 3'd0;
                    end
                end
                S_RD_ID: begin
                    if (w_lat_hit) begin
                        id_value <= sys_readdata;
                        r_lat    <= 3'd0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
                        r_state     <= S_RD_TS;
                        sys_address <= 1'b1;
`else
                        r_state  <= S_CHECK;
                        sys_read <= 1'b0;
`endif
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
`ifdef SYSID_CHECK_TIMESTAMP_EN
                S_RD_TS: begin
                    if (w_lat_hit) begin
                        ts_value    <= sys_readdata;
                        r_lat       <= 3'd0;
                        r_state     <= S_CHECK;
                        sys_read    <= 1'b0;
                        sys_address <= 1'b0;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
`endif
                S_CHECK: begin
                    id_ok <= w_id_match;
                    ts_ok <= w_ts_match;
                    if ((w_id_match && w_ts_match) || (retry_count == RETRY_MAX)) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        retry_count <= retry_count + 3'd1;
                        r_state     <= S_RD_ID;
                        r_lat       <= 3'd0;
                        sys_read    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    busy        <= 1'b0;
                    sys_read    <= 1'b0;
                    sys_address <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - self-checking bench for sysid_checker (three latency/retry configurations)
module tb_sysid_checker;

`ifdef SYSID_CHECK_TIMESTAMP_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif
    localparam logic [31:0] EID  = 32'd0;
    localparam logic [31:0] ETS  = 32'd1390424643;
    localparam logic [31:0] BAD_TS = 32'h12345678;
    localparam logic [31:0] BAD_ID = 32'hDEADBEEF;
    localparam int NRD = TS ? 2 : 1;
    localparam int NI  = 3;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 3 : 7;
    endfunction
    function automatic int mr_of(input int g);
        return (g == 2) ? 0 : 3;
    endfunction
    function automatic int plen(input int g);
        return NRD * (lat_of(g) + 1) + 1;
    endfunction

    logic clock;
    logic reset;
    logic start;

    logic        sa  [NI];
    logic        sr  [NI];
    logic        bz  [NI];
    logic        dn  [NI];
    logic        iok [NI];
    logic        tok [NI];
    logic [31:0] rd  [NI];
    logic [31:0] idv [NI];
    logic [31:0] tsv [NI];
    logic [2:0]  rc  [NI];

    logic [31:0] id_tbl [8];
    logic [31:0] ts_tbl [8];

    int          t     [NI];
    int          n     [NI];
    int          p_cur [NI];
    logic [31:0] l_id  [NI];
    logic [31:0] l_ts  [NI];
    bit          l_iok [NI];
    bit          l_tok [NI];
    int          l_rc  [NI];

    int checks;
    int errors;

    int first_done [NI];
    int n_done     [NI];
    int n_rd       [NI];
    int n_a1       [NI];
    int n_pass     [NI];
    bit prev_rd    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sysid_checker #(
            .EXPECTED_ID       (EID),
            .EXPECTED_TIMESTAMP(ETS),
            .READ_LATENCY      (lat_of(g)),
            .MAX_RETRIES       (mr_of(g))
        ) u_dut (
            .clock       (clock),
            .reset       (reset),
            .start       (start),
            .sys_address (sa[g]),
            .sys_read    (sr[g]),
            .sys_readdata(rd[g]),
            .busy        (bz[g]),
            .done        (dn[g]),
            .id_ok       (iok[g]),
            .ts_ok       (tok[g]),
            .id_value    (idv[g]),
            .ts_value    (tsv[g]),
            .retry_count (rc[g])
        );
        // Slave answers with the table row of the pass the model says is running.
        assign rd[g] = sa[g] ? ts_tbl[p_cur[g]] : id_tbl[p_cur[g]];
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pass_ok(input int p);
        return (id_tbl[p] == EID) && (!TS || ts_tbl[p] == ETS);
    endfunction

    function automatic int passes_needed(input int g);
        for (int p = 0; p <= mr_of(g); p++)
            if (pass_ok(p)) return p + 1;
        return mr_of(g) + 1;
    endfunction

    task automatic set_tables(input logic [31:0] idw, input logic [31:0] tsw);
        for (int i = 0; i < 8; i++) begin
            id_tbl[i] = idw;
            ts_tbl[i] = tsw;
        end
    endtask

    task automatic model_proc();
        forever begin
            @(posedge clock or posedge reset);
            for (int g = 0; g < NI; g++) begin
                if (reset) begin
                    t[g] = 0; n[g] = 1; p_cur[g] = 0;
                    l_id[g] = 32'd0; l_ts[g] = 32'd0; l_iok[g] = 1'b0; l_tok[g] = 1'b0; l_rc[g] = 0;
                end else if (t[g] == 0) begin
                    if (start) begin
                        t[g] = 1; p_cur[g] = 0; n[g] = passes_needed(g);
                    end
                end else if (t[g] == n[g] * plen(g) + 1) begin
                    t[g] = 0;
                end else begin
                    t[g]++;
                    if (t[g] == n[g] * plen(g) + 1) begin
                        l_id[g]  = id_tbl[n[g] - 1];
                        l_ts[g]  = TS ? ts_tbl[n[g] - 1] : 32'd0;
                        l_iok[g] = (id_tbl[n[g] - 1] == EID);
                        l_tok[g] = TS ? (ts_tbl[n[g] - 1] == ETS) : 1'b1;
                        l_rc[g]  = n[g] - 1;
                    end else begin
                        p_cur[g] = (t[g] - 1) / plen(g);
                    end
                end
            end
        end
    endtask

    task automatic compare_proc();
        bit e_bz, e_dn, e_rd, e_ad, e_iok, e_tok, vals;
        int e_rc, p, o, td;
        forever begin
            @(negedge clock);
            for (int g = 0; g < NI; g++) begin
                td = n[g] * plen(g) + 1;
                vals = 1'b1;
                if (t[g] == 0 || t[g] == td) begin
                    e_bz = (t[g] != 0); e_dn = (t[g] == td); e_rd = 1'b0; e_ad = 1'b0;
                    e_iok = l_iok[g]; e_tok = l_tok[g]; e_rc = l_rc[g];
                end else begin
                    p = (t[g] - 1) / plen(g);
                    o = (t[g] - 1) % plen(g);
                    e_bz = 1'b1; e_dn = 1'b0;
                    e_rd = (o < NRD * (lat_of(g) + 1));
                    e_ad = TS && (o >= lat_of(g) + 1) && (o < 2 * (lat_of(g) + 1));
                    e_rc = p;
                    e_iok = (p > 0) && (id_tbl[p - 1] == EID);
                    e_tok = (p > 0) && (!TS || ts_tbl[p - 1] == ETS);
                    vals = 1'b0;
                end
                chk($sformatf("cyc_busy[%0d]", g), bz[g], e_bz);
                chk($sformatf("cyc_done[%0d]", g), dn[g], e_dn);
                chk($sformatf("cyc_read[%0d]", g), sr[g], e_rd);
                chk($sformatf("cyc_addr[%0d]", g), sa[g], e_ad);
                chk($sformatf("cyc_retry[%0d]", g), rc[g], e_rc);
                chk($sformatf("cyc_id_ok[%0d]", g), iok[g], e_iok);
                chk($sformatf("cyc_ts_ok[%0d]", g), tok[g], e_tok);
                if (vals) begin
                    chk($sformatf("cyc_id_value[%0d]", g), idv[g], l_id[g]);
                    chk($sformatf("cyc_ts_value[%0d]", g), tsv[g], l_ts[g]);
                end
            end
        end
    endtask

    task automatic run_check(input bit extra_start);
        int k;
        bit all_idle;
        for (int g = 0; g < NI; g++) begin
            first_done[g] = 0; n_done[g] = 0; n_rd[g] = 0; n_a1[g] = 0; n_pass[g] = 0; prev_rd[g] = 1'b0;
        end
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        k = 1;
        all_idle = 1'b0;
        while (k <= 300 && !all_idle) begin
            all_idle = 1'b1;
            for (int g = 0; g < NI; g++) begin
                if (dn[g]) begin
                    n_done[g]++;
                    if (first_done[g] == 0) first_done[g] = k;
                end
                if (sr[g]) n_rd[g]++;
                if (sr[g] && sa[g]) n_a1[g]++;
                if (sr[g] && !prev_rd[g]) n_pass[g]++;
                prev_rd[g] = sr[g];
                if (bz[g]) all_idle = 1'b0;
            end
            if (extra_start && k == 2) start = 1'b1;
            if (extra_start && k == 3) start = 1'b0;
            if (!all_idle) begin
                @(negedge clock);
                k++;
            end
        end
        chk("run_check_completes", all_idle, 1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (k < 300 && (bz[0] || bz[1] || bz[2])) begin
            @(negedge clock);
            k++;
        end
        chk("wait_idle_completes", k < 300, 1);
    endtask

    task automatic stimulus();
        int k, gap, dcount;
        bit seen_done, counting;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", bz[0], 0);
        chk("rst_read", sr[1], 0);
        chk("rst_id_value", idv[0], 0);
        chk("rst_ts_ok", tok[0], 0);
        chk("rst_retry", rc[2], 0);

        // Clean pass, with a start pulse that lands mid-check and must be ignored.
        set_tables(EID, ETS);
        run_check(1'b1);
        chk("pass_lat_L0", first_done[0], TS ? 4 : 3);
        chk("pass_lat_L3", first_done[1], TS ? 10 : 6);
        chk("pass_lat_L7", first_done[2], TS ? 18 : 10);
        chk("pass_read_cycles_L3", n_rd[1], TS ? 8 : 4);
        chk("pass_addr1_cycles_L3", n_a1[1], TS ? 4 : 0);
        chk("pass_done_pulses", n_done[0], 1);
        chk("pass_id_ok", iok[0], 1);
        chk("pass_ts_ok", tok[0], 1);
        chk("pass_retry", rc[0], 0);
        chk("pass_ts_value", tsv[0], TS ? 64'd1390424643 : 64'd0);

        // Persistent timestamp mismatch.
        set_tables(EID, BAD_TS);
        run_check(1'b0);
        chk("tsbad_passes", n_pass[0], TS ? 4 : 1);
        chk("tsbad_retry", rc[0], TS ? 3 : 0);
        chk("tsbad_ts_ok", tok[0], TS ? 0 : 1);
        chk("tsbad_id_ok", iok[0], 1);
        chk("tsbad_ts_value", tsv[0], TS ? 64'h12345678 : 64'd0);
        chk("tsbad_done_pulses", n_done[0], 1);
        chk("tsbad_lat_L0", first_done[0], TS ? 13 : 3);
        chk("tsbad_noretry_passes", n_pass[2], 1);
        chk("tsbad_noretry_retry", rc[2], 0);

        // Transient timestamp mismatch on the first pass only.
        set_tables(EID, ETS);
        ts_tbl[0] = BAD_TS;
        run_check(1'b0);
        chk("tstrans_retry", rc[0], TS ? 1 : 0);
        chk("tstrans_ts_ok", tok[0], 1);
        chk("tstrans_lat_L3", first_done[1], TS ? 19 : 6);

        // Persistent ID mismatch.
        set_tables(BAD_ID, ETS);
        run_check(1'b0);
        chk("idbad_retry", rc[1], 3);
        chk("idbad_id_ok", iok[1], 0);
        chk("idbad_id_value", idv[1], 64'hDEADBEEF);
        chk("idbad_passes", n_pass[1], 4);
        chk("idbad_noretry_retry", rc[2], 0);
        chk("idbad_noretry_id_ok", iok[2], 0);

        // Asynchronous reset in the middle of a read.
        set_tables(EID, ETS);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        k = 0;
        while (k < 50 && !(sr[1] && (sa[1] || !TS))) begin
            @(negedge clock);
            k++;
        end
        chk("rstmid_reached_read", k < 50, 1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_read_async", {sr[0], sr[1], sr[2]}, 0);
        chk("rstmid_busy_async", {bz[0], bz[1], bz[2]}, 0);
        chk("rstmid_id_value", idv[1], 0);
        chk("rstmid_retry", rc[1], 0);
        @(negedge clock);
        @(negedge clock); reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (dn[0] || dn[1] || dn[2]) dcount++;
        end
        chk("rstmid_no_done", dcount, 0);
        run_check(1'b0);
        chk("rstmid_clean_lat", first_done[0], TS ? 4 : 3);
        chk("rstmid_clean_id_ok", iok[1], 1);
        chk("rstmid_clean_ts_ok", tok[1], 1);

        // Start held high: back-to-back checks with one idle cycle between.
        @(negedge clock); start = 1'b1;
        dcount = 0; gap = 0; seen_done = 1'b0; counting = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (dn[0]) dcount++;
            if (seen_done && counting) begin
                if (bz[0]) counting = 1'b0;
                else gap++;
            end
            if (dn[0]) seen_done = 1'b1;
        end
        start = 1'b0;
        chk("b2b_idle_gap", gap, 1);
        chk("b2b_done_pulses", dcount, TS ? 12 : 15);
        wait_idle();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        set_tables(EID, ETS);
        for (int g = 0; g < NI; g++) begin
            t[g] = 0; n[g] = 1; p_cur[g] = 0;
            l_id[g] = 32'd0; l_ts[g] = 32'd0; l_iok[g] = 1'b0; l_tok[g] = 1'b0; l_rc[g] = 0;
        end
        fork
            model_proc();
            compare_proc();
            stimulus();
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
